groestl_io_slave: RTL
=====================

Name: groestl_io_slave

Overview:
Responder-side front-end for the hash core's 16-bit host port (init/load/fetch/ack/idata/odata). It packs host-loaded words into a message block, hands the block to the Grøstl compression core, and serves the resulting digest back one word per fetch. It sits between the host interface and the core datapath inside the hash top level.

Parameters:
IOSIZE, 16, host data word width
BLOCK_BITS, 512, message block width; WPB = BLOCK_BITS/IOSIZE = 32 words
DIGEST_BITS, 256, digest width; WPD = DIGEST_BITS/IOSIZE = 16 words

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
init  in  1  host: start new message (1-cycle pulse)
load  in  1  host: idata valid, held until ack
fetch  in  1  host: request next digest word, held until ack
idata  in  IOSIZE  host write data
ack  out  1  registered; one-cycle pulse per accepted load or served fetch
odata  out  IOSIZE  registered digest word, valid in the cycle ack is high
err  out  1  sticky protocol error flag
core_init  out  1  1-cycle pulse to core: reset chaining value
blk_data  out  BLOCK_BITS  assembled block; first loaded word at bits [BLOCK_BITS-1 -: IOSIZE]
blk_valid  out  1  1-cycle pulse: blk_data complete
core_busy  in  1  core compressing
digest  in  DIGEST_BITS  core output
digest_valid  in  1  1-cycle pulse: digest valid

Behaviour:
- Reset (rst_n=0, async): ack=0, odata=0, err=0, core_init=0, blk_valid=0, blk_data=0, wcnt=0, rptr=0, have_dig=0, state=FILL.
- States: FILL (accepting words), HASH (waiting for core).
- Priority on each edge: init > load > fetch.
- init: core_init=1 next cycle; wcnt=0, rptr=0, have_dig=0, err=0, state=FILL. Abandons HASH; a digest_valid arriving outside HASH is ignored. ack not asserted.
- load in FILL and core_busy=0: write idata to slot wcnt (MSB-first); ack=1 next cycle; wcnt++. When the accepted word is word WPB-1: wcnt=0, blk_valid=1 next cycle, state=HASH.
- load in HASH, or in FILL with core_busy=1: no capture, ack=0 (host stalls).
- Back-to-back: load held high is accepted every cycle while in FILL; ack high on consecutive cycles.
- HASH: on digest_valid, latch digest to internal register, have_dig=1, rptr=0, state=FILL.
- fetch accepted only when state=FILL, wcnt=0, have_dig=1, load=0: odata = digest word rptr (word 0 = bits [DIGEST_BITS-1 -: IOSIZE]); ack=1 next cycle; rptr++. Otherwise no ack (host times out).
- rptr wrap: fetch at rptr=WPD-1 serves the last word, then rptr=0. Any further fetch still served (from word 0) but sets err=1 (over-read).
- err also set by a load arriving while state=HASH with wcnt=0 and blk_valid previous cycle (overrun attempt); err cleared only by init or reset.
- Load while a digest is pending, without fetching: allowed; the next block chains and the digest register is overwritten at the next digest_valid.
- ack and odata hold previous odata when ack=0; ack is never high for two different requests in one cycle.
- Latency: load/fetch sampled at edge N -> ack at edge N (registered, visible after N); blk_valid one cycle after the 32nd ack.

Test Plan:
- Reset mid-FILL after 5 loads, then 32 loads of 0x0000..0x001F -> blk_valid once after 32nd ack, blk_data[511:496]=0x0000, [15:0]=0x001F.
- load held high for 32 cycles with core_busy=0 -> ack high 32 consecutive cycles, state=HASH, 33rd load gets no ack.
- Core returns digest 0x0123...CDEF (16 words) -> 16 fetches give 0x0123 first, last word 0xCDEF, err=0; 17th fetch returns 0x0123 and err=1.
- fetch before any digest (have_dig=0) -> no ack for 100 cycles; init -> core_init pulse, err cleared.
- init during HASH, then digest_valid -> digest ignored, fetch not acked, next 32 loads accepted normally.
- load and fetch asserted same cycle with digest ready -> load acked, wcnt=1, fetch not served.

Source files
------------

// File: rtl/groestl_io_slave.sv
// groestl_io_slave: host-side word packer feeding the Grøstl core and serving the digest back
// one word per fetch.
module groestl_io_slave #(
    parameter int IOSIZE      = 16,
    parameter int BLOCK_BITS  = 512,
    parameter int DIGEST_BITS = 256
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   init,
    input  logic                   load,
    input  logic                   fetch,
    input  logic [IOSIZE-1:0]      idata,
    output logic                   ack,
    output logic [IOSIZE-1:0]      odata,
    output logic                   err,
    output logic                   core_init,
    output logic [BLOCK_BITS-1:0]  blk_data,
    output logic                   blk_valid,
    input  logic                   core_busy,
    input  logic [DIGEST_BITS-1:0] digest,
    input  logic                   digest_valid
);
    localparam int WPB = BLOCK_BITS / IOSIZE;
    localparam int WPD = DIGEST_BITS / IOSIZE;
    localparam int WW = $clog2(WPB);
    localparam int RW = $clog2(WPD);
    localparam logic [WW-1:0] W_LAST = WW'(WPB - 1);
    localparam logic [RW-1:0] R_LAST = RW'(WPD - 1);

    typedef enum logic {FILL, HASH} state_t;

    state_t                 state;
    logic [WW-1:0]          wcnt;
    logic [RW-1:0]          rptr;
    logic                   have_dig;
    logic                   wrapped;
    logic                   fin;
    logic [DIGEST_BITS-1:0] dig;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack       <= 1'b0;
            odata     <= '0;
            err       <= 1'b0;
            core_init <= 1'b0;
            blk_data  <= '0;
            blk_valid <= 1'b0;
            state     <= FILL;
            wcnt      <= '0;
            rptr      <= '0;
            have_dig  <= 1'b0;
            wrapped   <= 1'b0;
            fin       <= 1'b0;
            dig       <= '0;
        end else begin
            ack       <= 1'b0;
            core_init <= 1'b0;
            fin       <= 1'b0;
            // blk_valid trails the final word's ack by one cycle
            blk_valid <= fin & ~init;
            if (init) begin
                core_init <= 1'b1;
                wcnt      <= '0;
                rptr      <= '0;
                have_dig  <= 1'b0;
                wrapped   <= 1'b0;
                err       <= 1'b0;
                state     <= FILL;
            end else begin
                if (state == HASH && digest_valid) begin
                    dig      <= digest;
                    have_dig <= 1'b1;
                    rptr     <= '0;
                    wrapped  <= 1'b0;
                    state    <= FILL;
                end
                if (load) begin
                    if (state == FILL && !core_busy) begin
                        blk_data[BLOCK_BITS-1-IOSIZE*int'(wcnt) -: IOSIZE] <= idata;
                        ack <= 1'b1;
                        if (wcnt == W_LAST) begin
                            wcnt  <= '0;
                            fin   <= 1'b1;
                            state <= HASH;
                        end else begin
                            wcnt <= wcnt + 1'b1;
                        end
                    end else if (state == HASH && wcnt == '0 && blk_valid) begin
                        err <= 1'b1;
                    end
                end else if (fetch && state == FILL && wcnt == '0 && have_dig) begin
                    odata <= dig[DIGEST_BITS-1-IOSIZE*int'(rptr) -: IOSIZE];
                    ack   <= 1'b1;
                    rptr  <= (rptr == R_LAST) ? '0 : rptr + 1'b1;
                    // reading past the last word is still served but flagged
                    if (wrapped) err <= 1'b1;
                    if (rptr == R_LAST) wrapped <= 1'b1;
                end
            end
        end
    end
endmodule
